uart_rx: RTL and testbench

//  Receive side of the display-measure UART link and the consumer of the uart_tx

---
 rtl/uart_rx.sv | 74 +++++++
 tb/tb_uart_rx.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-FF synchroniser, centre sampling and stop-bit framing check
module uart_rx #(
  parameter int CLK_HZ = 125_000_000,
  parameter int BAUD   = 115200,
  parameter int DIV    = CLK_HZ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       ferr,
  output logic       busy
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_e;
  state_e        state_q, state_d;
  logic          rx_m_q, rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d, data_q, data_d;
  logic          valid_q, valid_d, ferr_q, ferr_d;
  logic          tick;
  assign tick = cnt_q == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_m_q  <= rx;
      rx_s_q  <= rx_m_q;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = rx_s_q ? IDLE : START;
      START:   state_d = !tick ? START : rx_s_q ? IDLE : DATA;
      DATA:    state_d = (tick && idx_q == 3'd7) ? STOP : DATA;
      STOP:    state_d = !tick ? STOP : rx_s_q ? IDLE : BRK;
      BRK:     state_d = rx_s_q ? IDLE : BRK;
      default: state_d = IDLE;
    endcase
  end
  // IDLE keeps the half-bit preload armed so the start edge needs no extra cycle
  always_comb begin
    cnt_d   = (state_q == IDLE) ? HALF : tick ? FULL : cnt_q - CW'(1);
    idx_d   = (state_q == START) ? 3'd0 : (state_q == DATA && tick) ? idx_q + 3'd1 : idx_q;
    shift_d = (state_q == DATA && tick) ? {rx_s_q, shift_q[7:1]} : shift_q;
    valid_d = state_q == STOP && tick && rx_s_q;
    ferr_d  = state_q == STOP && tick && !rx_s_q;
    data_d  = valid_d ? shift_q : data_q;
  end
  assign data  = data_q;
  assign valid = valid_q;
  assign ferr  = ferr_q;
  assign busy  = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx with a queue scoreboard checked by a concurrent monitor
module tb_uart_rx;
  localparam int DIV = 16;
  localparam int BP  = DIV * 10;
  logic       clk, rst, rx;
  logic [7:0] data;
  logic       valid, ferr, busy;
  logic [7:0] exp_q[$];
  int         checks, failures, ferr_cnt;
  uart_rx #(.CLK_HZ(1_600_000), .BAUD(100_000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid), .ferr(ferr), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, req);
    end
  endtask
  task automatic send(input logic [7:0] b, input logic stop_v, input int bp);
    rx = 1'b0;
    #bp;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #bp;
    end
    rx = stop_v;
    #bp;
  endtask
  task automatic push_send(input logic [7:0] b, input int bp);
    exp_q.push_back(b);
    send(b, 1'b1, bp);
  endtask
  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] e;
    int n, f0;
    checks = 0; failures = 0; ferr_cnt = 0;
    rst = 1'b1; rx = 1'b1;
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (valid) begin
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL unexpected_valid data=%h", data);
            end else begin
              e = exp_q.pop_front();
              if (data !== e) begin
                failures++;
                $display("FAIL rx_byte got=%h exp=%h", data, e);
              end
            end
          end
          if (ferr) ferr_cnt++;
          if (valid && ferr) begin
            checks++;
            failures++;
            $display("FAIL valid_ferr_overlap got=1 exp=0");
          end
        end
      end
    join_none
    repeat (3) @(negedge clk);
    chk("rst_data", int'(data), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_ferr", int'(ferr), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    // loopback-style bytes
    push_send(8'h00, BP);
    push_send(8'h28, BP);
    push_send(8'h5A, BP);
    #(2 * BP);
    chk("t1_drain", exp_q.size(), 0);
    chk("t1_ferr", ferr_cnt, 0);
    // glitch shorter than half a bit
    @(negedge clk);
    rx = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == DIV / 4) rx = 1'b1;
    end while ((busy || n < DIV / 4) && n < 3 * DIV);
    chk("t2_busy_fall_ok", int'(n <= DIV / 2 + 3), 1);
    #(2 * BP);
    chk("t2_ferr", ferr_cnt, 0);
    chk("t2_data", int'(data), 'h5A);
    // framing error with held-low line
    f0 = ferr_cnt;
    send(8'hA5, 1'b0, BP);
    #(3 * BP);
    rx = 1'b1;
    #(2 * BP);
    chk("t3_one_ferr", ferr_cnt - f0, 1);
    chk("t3_data_kept", int'(data), 'h5A);
    chk("t3_no_valid", exp_q.size(), 0);
    push_send(8'h81, BP);
    #(2 * BP);
    chk("t3_fresh", exp_q.size(), 0);
    // back-to-back frames, zero idle gap
    for (int i = 0; i < 16; i++) push_send(8'(i), BP);
    #(2 * BP);
    chk("t4_drain", exp_q.size(), 0);
    chk("t4_data", int'(data), 'h0F);
    // rate skew +3% then -3%
    push_send(8'h55, BP + 5);
    push_send(8'hFF, BP + 5);
    #(2 * BP);
    push_send(8'h55, BP - 5);
    push_send(8'hFF, BP - 5);
    #(2 * BP);
    chk("t5_drain", exp_q.size(), 0);
    // reset during bit 4 of 8'h3C
    rx = 1'b0;
    #BP;
    for (int i = 0; i < 4; i++) begin
      rx = i >= 2;
      #BP;
    end
    rx = 1'b1;
    #(BP / 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_data", int'(data), 0);
    chk("t6_rst_valid", int'(valid), 0);
    chk("t6_rst_ferr", int'(ferr), 0);
    chk("t6_rst_busy", int'(busy), 0);
    rst = 1'b0;
    #(2 * BP);
    push_send(8'hC3, BP);
    #(2 * BP);
    chk("t6_drain", exp_q.size(), 0);
    chk("t6_data", int'(data), 'hC3);
    chk("total_ferr", ferr_cnt, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
